npu_v3_crossbar_model: RTL and testbench

//  Parametrised, clock-synchronous behavioural model of an NPU RRAM crossbar macro.
//  It replaces the v2 256x256 macro model in controller testbenches.

---
 rtl/npu_v3_pkg.sv | 44 ++++
 rtl/npu_v3_sel_chain.sv | 37 +++
 rtl/npu_v3_crossbar_model.sv | 206 ++++++++++++++++++++
 tb/tb_npu_v3_crossbar_model.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_v3_pkg.sv
// Shared types, width helpers and saturating arithmetic
// for the npu_v3 crossbar behavioural model.
package npu_v3_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_WR,
    S_FIN
  } state_t;

  function automatic int calc_aw(int nwl, int nbl);
    return $clog2((nwl > nbl) ? nwl : nbl) + 1;
  endfunction

  function automatic int calc_acc_w(int ib, int wb, int nwl);
    return ib + wb + $clog2(nwl);
  endfunction

  localparam int AW = calc_aw(32, 32);
  localparam int ACC_W = calc_acc_w(8, 6, 32);

  function automatic logic [15:0] sat_inc(
    logic [15:0] v,
    logic [15:0] mx
  );
    return (v >= mx) ? mx : v + 16'd1;
  endfunction

  function automatic logic [15:0] sat_dec(logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  function automatic logic [31:0] sat_q(
    logic [31:0] a,
    int sh,
    logic [31:0] mx
  );
    logic [31:0] q;
    q = a >> sh;
    return (q > mx) ? mx : q;
  endfunction

endpackage

// File: rtl/npu_v3_sel_chain.sv
// Serial select chain shifted on a strobe rising edge.
// Shifts are locked out while the compute engine is busy.
module npu_v3_sel_chain
  import npu_v3_pkg::*;
#(
  parameter int N = 32,
  parameter int DIR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic         d,
  input  logic         busy,
  output logic [N-1:0] sel,
  output logic         err
);

  logic strobe_q;
  logic edge_hit;

  assign edge_hit = strobe & ~strobe_q;
  assign err = edge_hit & busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      sel <= '0;
    end else begin
      strobe_q <= strobe;
      if (edge_hit && !busy) begin
        if (DIR == 0) sel <= {sel[N-2:0], d};
        else sel <= {d, sel[N-1:1]};
      end
    end
  end

endmodule

// File: rtl/npu_v3_crossbar_model.sv
// Behavioural RRAM crossbar macro: select chains, weight
// array, input buffer, serial MAC engine and ADC readout.
module npu_v3_crossbar_model
  import npu_v3_pkg::*;
#(
  parameter int NUM_WL = 32,
  parameter int NUM_BL = 32,
  parameter int IN_BITS = 8,
  parameter int W_BITS = 6,
  parameter int W_INIT = 4,
  parameter int Q_SHIFT = 8,
  parameter int CFG_DEPTH = 16,
  localparam int ADDR_W = calc_aw(NUM_WL, NUM_BL)
) (
  input  logic                clk_all,
  input  logic                reset_all,
  input  logic [2:0]          CLKREG,
  input  logic [2:0]          DINSWREG,
  input  logic                CLKDAC,
  input  logic [IN_BITS-1:0]  DIN,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic                DACBL_SW,
  input  logic                SET,
  input  logic                RESET,
  input  logic                DACBL_SW2,
  input  logic                CLKADC,
  input  logic                RD_MODE,
  input  logic [ADDR_W-2:0]   RD_ROW,
  output logic [W_BITS-1:0]   DOUT,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int SUM_W = calc_acc_w(IN_BITS, W_BITS, NUM_WL);
  localparam int RW = $clog2(NUM_WL);
  localparam int CW = $clog2(NUM_BL);
  localparam int QW = $clog2(CFG_DEPTH);
  localparam logic [15:0] WMAX = 16'((1 << W_BITS) - 1);

  logic [NUM_WL-1:0] wl_sel;
  logic [NUM_BL-1:0] tia_sel;
  logic [NUM_BL-1:0] bl_sel;
  logic [2:0] chain_err;

  logic [W_BITS-1:0] w [NUM_WL][NUM_BL];
  logic [IN_BITS-1:0] inbuf [NUM_WL];
  logic [W_BITS-1:0] res [NUM_BL];
  logic [CFG_DEPTH-1:0][IN_BITS-1:0] cfg;
  logic cfg_unused;

  logic dac_q, prog_q, start_q, adc_q;
  logic dac_e, prog_e, start_e, adc_e;
  logic busy, start, prog_ok, last_row;
  logic err;
  logic [W_BITS-1:0] dout, rd_data;
  logic [ADDR_W-2:0] alo;

  state_t state, state_n;
  logic [RW-1:0] row;
  logic [CW-1:0] col, col_n;
  logic col_hit;
  logic [SUM_W-1:0] acc;

  npu_v3_sel_chain #(.N(NUM_WL), .DIR(0)) u_wl (
    .clk(clk_all), .rst_n(reset_all),
    .strobe(CLKREG[0]), .d(DINSWREG[0]),
    .busy(busy), .sel(wl_sel), .err(chain_err[0])
  );

  npu_v3_sel_chain #(.N(NUM_BL), .DIR(1)) u_tia (
    .clk(clk_all), .rst_n(reset_all),
    .strobe(CLKREG[1]), .d(DINSWREG[1]),
    .busy(busy), .sel(tia_sel), .err(chain_err[1])
  );

  npu_v3_sel_chain #(.N(NUM_BL), .DIR(0)) u_bl (
    .clk(clk_all), .rst_n(reset_all),
    .strobe(CLKREG[2]), .d(DINSWREG[2]),
    .busy(busy), .sel(bl_sel), .err(chain_err[2])
  );

  assign alo = ADDR[ADDR_W-2:0];
  assign cfg_unused = ^cfg;
  assign dac_e = CLKDAC & ~dac_q;
  assign prog_e = DACBL_SW & ~prog_q;
  assign start_e = DACBL_SW2 & ~start_q;
  assign adc_e = CLKADC & ~adc_q;
  assign busy = (state != S_IDLE);
  assign start = start_e & ~busy;
  // a compute start wins over a program pulse in the same cycle
  assign prog_ok = prog_e & (SET ^ RESET) & ~busy & ~start;
  assign last_row = (int'(row) == NUM_WL - 1);

  assign DOUT = dout;
  assign BUSY = busy;
  assign DONE = (state == S_FIN);
  assign ERR = err;

  always_ff @(posedge clk_all) begin
    if (!reset_all) begin
      {dac_q, prog_q, start_q, adc_q} <= '0;
    end else begin
      {dac_q, prog_q, start_q, adc_q} <=
        {CLKDAC, DACBL_SW, DACBL_SW2, CLKADC};
    end
  end

  // lowest selected column; past the current one once running
  always_comb begin
    col_n = '0;
    col_hit = 1'b0;
    for (int i = 0; i < NUM_BL; i++) begin
      if (!col_hit && tia_sel[i] &&
          (state == S_IDLE || i > int'(col))) begin
        col_n = CW'(i);
        col_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_all) begin
    if (!reset_all) state <= S_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = col_hit ? S_ACC : S_FIN;
      S_ACC: if (last_row) state_n = S_WR;
      S_WR: state_n = col_hit ? S_ACC : S_FIN;
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (!ADDR[ADDR_W-1] && int'(alo) < NUM_BL) begin
      if (!RD_MODE) rd_data = res[alo[CW-1:0]];
      else if (int'(RD_ROW) < NUM_WL)
        rd_data = w[RD_ROW[RW-1:0]][alo[CW-1:0]];
    end
  end

  always_ff @(posedge clk_all) begin
    if (!reset_all) begin
      row <= '0;
      col <= '0;
      acc <= '0;
      err <= 1'b0;
      dout <= '0;
      cfg <= '0;
      for (int r = 0; r < NUM_WL; r++) begin
        inbuf[r] <= '0;
        for (int c = 0; c < NUM_BL; c++)
          w[r][c] <= W_BITS'(W_INIT);
      end
      for (int c = 0; c < NUM_BL; c++) res[c] <= '0;
    end else begin
      if (dac_e) begin
        if (!ADDR[ADDR_W-1] && int'(alo) < NUM_WL)
          inbuf[alo[RW-1:0]] <= DIN;
        else if (ADDR[ADDR_W-1] && int'(alo) < CFG_DEPTH)
          cfg[alo[QW-1:0]] <= DIN;
      end
      if (prog_ok) begin
        for (int r = 0; r < NUM_WL; r++) begin
          for (int c = 0; c < NUM_BL; c++) begin
            if (wl_sel[r] && bl_sel[c]) begin
              if (SET)
                w[r][c] <= W_BITS'(sat_inc(16'(w[r][c]), WMAX));
              else
                w[r][c] <= W_BITS'(sat_dec(16'(w[r][c])));
            end
          end
        end
      end
      if ((prog_e && !prog_ok) || (|chain_err)) err <= 1'b1;
      if (adc_e) dout <= rd_data;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            col <= col_n;
            row <= '0;
            acc <= '0;
          end
        end
        S_ACC: begin
          if (wl_sel[row])
            acc <= acc + SUM_W'(inbuf[row]) * SUM_W'(w[row][col]);
          row <= last_row ? '0 : row + 1'b1;
        end
        S_WR: begin
          res[col] <= W_BITS'(sat_q(32'(acc), Q_SHIFT, 32'(WMAX)));
          col <= col_n;
          row <= '0;
          acc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_v3_crossbar_model.sv
// Directed and randomised bench for npu_v3_crossbar_model,
// checked against a plain behavioural model of the macro.
module tb_npu_v3_crossbar_model;
  import npu_v3_pkg::*;

  localparam int NWL = 32;
  localparam int NBL = 32;
  localparam int WMX = 63;

  logic clk_all = 1'b0;
  logic reset_all = 1'b0;
  logic [2:0] CLKREG = '0;
  logic [2:0] DINSWREG = '0;
  logic CLKDAC = 1'b0;
  logic [7:0] DIN = '0;
  logic [5:0] ADDR = '0;
  logic DACBL_SW = 1'b0;
  logic SET = 1'b0;
  logic RESET = 1'b0;
  logic DACBL_SW2 = 1'b0;
  logic CLKADC = 1'b0;
  logic RD_MODE = 1'b0;
  logic [4:0] RD_ROW = '0;
  logic [5:0] DOUT;
  logic BUSY, DONE, ERR;

  int total = 0;
  int bad = 0;

  bit wl_m[NWL];
  bit tia_m[NBL];
  bit bl_m[NBL];
  int w_m[NWL][NBL];
  int in_m[NWL];
  int res_m[NBL];

  npu_v3_crossbar_model dut (
    .clk_all(clk_all), .reset_all(reset_all),
    .CLKREG(CLKREG), .DINSWREG(DINSWREG),
    .CLKDAC(CLKDAC), .DIN(DIN), .ADDR(ADDR),
    .DACBL_SW(DACBL_SW), .SET(SET), .RESET(RESET),
    .DACBL_SW2(DACBL_SW2), .CLKADC(CLKADC),
    .RD_MODE(RD_MODE), .RD_ROW(RD_ROW),
    .DOUT(DOUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 clk_all = ~clk_all;

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NWL; r++) begin
      wl_m[r] = 0;
      in_m[r] = 0;
      for (int c = 0; c < NBL; c++) w_m[r][c] = 4;
    end
    for (int c = 0; c < NBL; c++) begin
      tia_m[c] = 0;
      bl_m[c] = 0;
      res_m[c] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_all);
    reset_all = 1'b0;
    @(negedge clk_all);
    @(negedge clk_all);
    reset_all = 1'b1;
    model_reset();
  endtask

  task automatic shift(int ch, bit d);
    DINSWREG[ch] = d;
    CLKREG[ch] = 1'b1;
    @(negedge clk_all);
    CLKREG[ch] = 1'b0;
    @(negedge clk_all);
    if (ch == 1) begin
      for (int i = 0; i < NBL - 1; i++) tia_m[i] = tia_m[i+1];
      tia_m[NBL-1] = d;
    end else if (ch == 0) begin
      for (int i = NWL - 1; i > 0; i--) wl_m[i] = wl_m[i-1];
      wl_m[0] = d;
    end else begin
      for (int i = NBL - 1; i > 0; i--) bl_m[i] = bl_m[i-1];
      bl_m[0] = d;
    end
  endtask

  task automatic set_chain(int ch, logic [31:0] p);
    for (int s = 0; s < 32; s++)
      shift(ch, p[(ch == 1) ? s : 31 - s]);
  endtask

  task automatic model_prog(bit s);
    for (int r = 0; r < NWL; r++)
      for (int c = 0; c < NBL; c++)
        if (wl_m[r] && bl_m[c]) begin
          if (s) w_m[r][c] = (w_m[r][c] < WMX) ? w_m[r][c] + 1 : WMX;
          else w_m[r][c] = (w_m[r][c] > 0) ? w_m[r][c] - 1 : 0;
        end
  endtask

  task automatic prog(bit s, bit r);
    SET = s;
    RESET = r;
    DACBL_SW = 1'b1;
    @(negedge clk_all);
    DACBL_SW = 1'b0;
    SET = 1'b0;
    RESET = 1'b0;
    @(negedge clk_all);
    if (s ^ r) model_prog(s);
  endtask

  task automatic write_in(int a, int d);
    ADDR = 6'(a);
    DIN = 8'(d);
    CLKDAC = 1'b1;
    @(negedge clk_all);
    CLKDAC = 1'b0;
    @(negedge clk_all);
    if (a < NWL) in_m[a] = d;
  endtask

  task automatic rd(bit mode, int row, int addr,
                    output logic [5:0] v);
    RD_MODE = mode;
    RD_ROW = 5'(row);
    ADDR = 6'(addr);
    CLKADC = 1'b1;
    @(negedge clk_all);
    v = DOUT;
    CLKADC = 1'b0;
    @(negedge clk_all);
  endtask

  task automatic rd_chk(string tag, bit mode, int row, int addr);
    logic [5:0] v;
    int e;
    rd(mode, row, addr, v);
    if (addr >= NBL || row >= NWL) e = 0;
    else e = mode ? w_m[row][addr] : res_m[addr];
    chk(tag, v, e);
  endtask

  task automatic model_compute();
    for (int c = 0; c < NBL; c++) begin
      if (tia_m[c]) begin
        int s;
        s = 0;
        for (int r = 0; r < NWL; r++)
          if (wl_m[r]) s += in_m[r] * w_m[r][c];
        s = s / 256;
        res_m[c] = (s > WMX) ? WMX : s;
      end
    end
  endtask

  task automatic run_compute(string tag, bit with_prog);
    int k, lat, cyc, busy_bad;
    bit seen;
    k = 0;
    for (int c = 0; c < NBL; c++) if (tia_m[c]) k++;
    lat = 1 + k * (NWL + 1) + 1;
    DACBL_SW2 = 1'b1;
    if (with_prog) begin
      SET = 1'b1;
      DACBL_SW = 1'b1;
    end
    cyc = 1;
    seen = 0;
    busy_bad = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk_all);
      cyc++;
      DACBL_SW2 = 1'b0;
      DACBL_SW = 1'b0;
      SET = 1'b0;
      if (DONE) seen = 1;
      else if (!BUSY) busy_bad++;
    end
    chk({tag, " done_cycle"}, cyc, lat);
    chk({tag, " busy_gap"}, busy_bad, 0);
    chk({tag, " busy_at_done"}, BUSY, 1);
    @(negedge clk_all);
    chk({tag, " done_pulse"}, DONE, 0);
    chk({tag, " busy_after"}, BUSY, 0);
    model_compute();
  endtask

  initial begin
    logic [5:0] v;
    int n;
    model_reset();
    do_reset();

    chk("t1 busy", BUSY, 0);
    chk("t1 done", DONE, 0);
    chk("t1 err", ERR, 0);
    chk("t1 dout", DOUT, 0);
    rd(1, 0, 3, v);
    chk("t1 w03", v, 4);
    rd(0, 0, 3, v);
    chk("t1 res3", v, 0);
    chk("t1 err_after", ERR, 0);

    shift(0, 1);
    shift(0, 1);
    repeat (30) shift(0, 0);
    repeat (30) shift(2, 0);
    shift(2, 1);
    shift(2, 1);
    repeat (3) prog(1, 0);
    rd(1, 31, 1, v);
    chk("t2 w31_1", v, 7);
    rd_chk("t2 w31_0", 1, 31, 0);
    rd_chk("t2 w30_1", 1, 30, 1);
    rd_chk("t2 w30_0", 1, 30, 0);
    rd_chk("t2 w29_0", 1, 29, 0);
    rd_chk("t2 w31_2", 1, 31, 2);
    rd_chk("t2 w0_0", 1, 0, 0);
    chk("t2 err", ERR, 0);

    repeat (60) prog(1, 0);
    rd(1, 31, 0, v);
    chk("t3 sat_hi", v, 63);
    repeat (70) prog(0, 1);
    rd(1, 30, 1, v);
    chk("t3 sat_lo", v, 0);
    SET = 1'b1;
    DACBL_SW = 1'b1;
    repeat (5) @(negedge clk_all);
    DACBL_SW = 1'b0;
    SET = 1'b0;
    @(negedge clk_all);
    model_prog(1);
    rd_chk("t3 hold_one_pulse", 1, 31, 0);
    chk("t3 err_clean", ERR, 0);
    prog(1, 1);
    rd_chk("t3 both_nochange", 1, 31, 0);
    chk("t3 err_both", ERR, 1);
    prog(0, 0);
    rd_chk("t3 none_nochange", 1, 30, 0);

    do_reset();
    chk("t4 err_reset", ERR, 0);
    rd_chk("t4 w_reset", 1, 31, 0);
    for (int r = 0; r < NWL; r++) write_in(r, 255);
    write_in(6'h23, 8'haa);
    write_in(6'h3f, 8'h55);
    set_chain(0, 32'hffff_ffff);
    set_chain(1, 32'h0000_0021);
    run_compute("t4", 0);
    rd(0, 0, 0, v);
    chk("t4 res0", v, 63);
    rd(0, 0, 5, v);
    chk("t4 res5", v, 63);
    for (int c = 0; c < NBL; c++) rd_chk("t4 res", 0, 0, c);
    rd(0, 0, 5, v);
    @(negedge clk_all);
    @(negedge clk_all);
    chk("t4 dout_hold", DOUT, 63);

    for (int r = 0; r < NWL; r++) write_in(r, 0);
    DACBL_SW2 = 1'b1;
    @(negedge clk_all);
    DACBL_SW2 = 1'b0;
    rd(0, 0, 0, v);
    chk("t5 read_busy", v, 63);
    chk("t5 busy", BUSY, 1);
    repeat (5) @(negedge clk_all);
    reset_all = 1'b0;
    @(negedge clk_all);
    chk("t5 abort_busy", BUSY, 0);
    reset_all = 1'b1;
    model_reset();
    n = 0;
    repeat (80) begin
      @(negedge clk_all);
      if (DONE) n++;
    end
    chk("t5 no_done", n, 0);
    rd(0, 0, 0, v);
    chk("t5 res0", v, 0);
    rd(0, 0, 5, v);
    chk("t5 res5", v, 0);

    rd_chk("t6 rd_nbl", 0, 0, NBL);
    rd_chk("t6 rd_nbl_w", 1, 5, NBL);
    rd_chk("t6 rd_top", 1, 0, 63);
    set_chain(0, 32'hffff_ffff);
    set_chain(1, 32'h0000_0004);
    set_chain(2, 32'h0000_0004);
    for (int r = 0; r < NWL; r++)
      write_in(r, $urandom_range(0, 255));
    DACBL_SW2 = 1'b1;
    @(negedge clk_all);
    DACBL_SW2 = 1'b0;
    repeat (3) @(negedge clk_all);
    DINSWREG = 3'b111;
    CLKREG = 3'b111;
    SET = 1'b1;
    DACBL_SW = 1'b1;
    @(negedge clk_all);
    CLKREG = '0;
    DINSWREG = '0;
    DACBL_SW = 1'b0;
    SET = 1'b0;
    n = 0;
    while (BUSY && n < 200) begin
      @(negedge clk_all);
      n++;
    end
    chk("t6 busy_end", BUSY, 0);
    chk("t6 err_busy", ERR, 1);
    model_compute();
    rd_chk("t6 res2", 0, 0, 2);
    run_compute("t6b", 0);
    rd_chk("t6b res2", 0, 0, 2);
    rd_chk("t6b res1", 0, 0, 1);
    rd_chk("t6 w0_2", 1, 0, 2);

    do_reset();
    set_chain(0, 32'h0000_0001);
    set_chain(1, 32'h0000_0001);
    set_chain(2, 32'h0000_0001);
    write_in(0, 200);
    run_compute("t7", 1);
    chk("t7 err", ERR, 1);
    rd_chk("t7 w0_0", 1, 0, 0);
    rd_chk("t7 res0", 0, 0, 0);

    do_reset();
    repeat (20) begin
      set_chain(0, $urandom & $urandom);
      set_chain(2, $urandom & $urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 3) != 0)
        repeat (n) prog(1, 0);
      else
        repeat (n) prog(0, 1);
    end
    repeat (40)
      rd_chk("t8 w", 1, $urandom_range(0, NWL - 1),
             $urandom_range(0, NBL - 1));
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < NWL; r++)
        write_in(r, $urandom_range(0, (k == 0) ? 255 : 40));
      set_chain(0, $urandom);
      set_chain(1, $urandom & $urandom & $urandom);
      run_compute("t8", 0);
      for (int c = 0; c < NBL; c++) rd_chk("t8 res", 0, 0, c);
    end
    chk("t8 err", ERR, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
